serial_receiver: RTL and testbench

//   Receive-side counterpart of the team's serial transmitter: samples a serial bitstream
//   (MSB first, one bit per DIVIDER clocks) and hunts for SYNC_WORD to find byte alignment.

---
 rtl/serial_link_pkg.sv | 19 +
 rtl/serial_receiver_if.sv | 11 +
 rtl/serial_bit_clk_div.sv | 29 ++
 rtl/serial_receiver.sv | 126 ++++++++++++
 tb/tb_serial_receiver.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/serial_link_pkg.sv
// Constants and types shared by the serial transmitter and receiver.
package serial_link_pkg;

  localparam int unsigned BYTE_W             = 8;
  localparam int unsigned DIVIDER_DEFAULT    = 3;
  localparam int unsigned KA_TIMEOUT_DEFAULT = 16;
  localparam logic [BYTE_W-1:0] SYNC_WORD_DEFAULT = 8'hA5;

  typedef enum logic {
    HUNT,
    LOCKED
  } rx_state_t;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_receiver_if.sv
// Byte-wide valid/ready delivery port of the serial receiver.
interface serial_receiver_if;
  import serial_link_pkg::*;

  logic [BYTE_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/serial_bit_clk_div.sv
// Free-running bit-period divider; strobe_c marks the last clock of each bit period.
module serial_bit_clk_div
  import serial_link_pkg::*;
#(
  parameter int unsigned DIVIDER = DIVIDER_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  output logic strobe_c
);

  localparam int unsigned CNT_W = cnt_w(DIVIDER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDER - 1);

  logic [CNT_W-1:0] div_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (div_cnt == CNT_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

  assign strobe_c = (div_cnt == CNT_LAST);

endmodule

// File: rtl/serial_receiver.sv
// Serial receiver: hunts for the sync word, then delivers MSB-first bytes on valid/ready.
// Optional keep-alive relock behaviour is enabled with `define SERIAL_RX_RELOCK_EN.
module serial_receiver
  import serial_link_pkg::*;
#(
  parameter int unsigned       DIVIDER    = DIVIDER_DEFAULT,
  parameter logic [BYTE_W-1:0] SYNC_WORD  = SYNC_WORD_DEFAULT,
  parameter int unsigned       KA_TIMEOUT = KA_TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                serial_in,
  serial_receiver_if.master   rx,
  output logic                locked,
  output logic                overrun,
  output logic                lock_lost
);

  localparam int unsigned BIT_W = cnt_w(BYTE_W);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BYTE_W - 1);

  rx_state_t         state;
  logic [BYTE_W-2:0] shift_reg;
  logic [BIT_W-1:0]  bit_cnt;
  logic              strobe_c;
  logic [BYTE_W-1:0] shift_nxt_c;
  logic              byte_done_c;
  logic              deliver_c;
  logic              accept_c;

  serial_bit_clk_div #(.DIVIDER(DIVIDER)) u_bit_clk_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .strobe_c (strobe_c)
  );

  // Only seven history bits persist; the eighth is the bit being sampled now.
  assign shift_nxt_c = {shift_reg, serial_in};
  assign byte_done_c = strobe_c && (state == LOCKED) && (bit_cnt == BIT_LAST);
  assign accept_c    = !rx.out_valid || rx.out_ready;

`ifdef SERIAL_RX_RELOCK_EN
  localparam int unsigned KA_W = cnt_w(KA_TIMEOUT);
  localparam logic [KA_W-1:0] KA_LAST = KA_W'(KA_TIMEOUT - 1);

  logic [KA_W-1:0] ka_cnt;

  // A locked sync word is a keep-alive and is swallowed.
  assign deliver_c = byte_done_c && (shift_nxt_c != SYNC_WORD);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ka_cnt    <= '0;
      lock_lost <= 1'b0;
    end else begin
      lock_lost <= 1'b0;
      if (byte_done_c) begin
        if (shift_nxt_c == SYNC_WORD) begin
          ka_cnt <= '0;
        end else if (ka_cnt == KA_LAST) begin
          ka_cnt    <= '0;
          lock_lost <= 1'b1;
        end else begin
          ka_cnt <= ka_cnt + KA_W'(1);
        end
      end
    end
  end
`else
  logic ka_timeout_unused;

  assign ka_timeout_unused = (KA_TIMEOUT == 0);
  assign deliver_c         = byte_done_c;
  assign lock_lost         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= HUNT;
      shift_reg    <= '0;
      bit_cnt      <= '0;
      locked       <= 1'b0;
      overrun      <= 1'b0;
      rx.out_data  <= '0;
      rx.out_valid <= 1'b0;
    end else begin
      if (rx.out_valid && rx.out_ready) begin
        rx.out_valid <= 1'b0;
      end

      if (strobe_c) begin
        shift_reg <= shift_nxt_c[BYTE_W-2:0];
        case (state)
          HUNT: begin
            if (shift_nxt_c == SYNC_WORD) begin
              state   <= LOCKED;
              locked  <= 1'b1;
              bit_cnt <= '0;
            end
          end
          LOCKED: begin
            bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
`ifdef SERIAL_RX_RELOCK_EN
            if (byte_done_c && (shift_nxt_c != SYNC_WORD) && (ka_cnt == KA_LAST)) begin
              state  <= HUNT;
              locked <= 1'b0;
            end
`endif
          end
          default: state <= HUNT;
        endcase
      end

      // A new byte loads when the slot is empty or being drained this cycle.
      if (deliver_c) begin
        if (accept_c) begin
          rx.out_data  <= shift_nxt_c;
          rx.out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_receiver.sv
// Scoreboard bench for serial_receiver (DIVIDER=3, SYNC_WORD=A5); define SERIAL_RX_RELOCK_EN for the relock run.
module tb_serial_receiver;
  import serial_link_pkg::*;

  localparam int unsigned DIV  = 3;
  localparam logic [7:0]  SYNC = 8'hA5;
  localparam int unsigned KA   = 2;
`ifdef SERIAL_RX_RELOCK_EN
  localparam int EXP_XFERS = 3;
`else
  localparam int EXP_XFERS = 8;
`endif

  logic clk       = 1'b0;
  logic reset_n   = 1'b0;
  logic serial_in = 1'b0;
  logic locked;
  logic overrun;
  logic lock_lost;

  serial_receiver_if bus ();

  serial_receiver #(
    .DIVIDER    (DIV),
    .SYNC_WORD  (SYNC),
    .KA_TIMEOUT (KA)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .serial_in (serial_in),
    .rx        (bus),
    .locked    (locked),
    .overrun   (overrun),
    .lock_lost (lock_lost)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int n_xfer = 0;
  logic [7:0] sb[$];
  int xfer_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Monitor: every accepted byte is checked against the head of the scoreboard.
  always begin
    @(negedge clk);
    #1;
    if (reset_n && bus.out_valid && bus.out_ready) begin
      n_xfer++;
      xfer_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL extra_byte: got %0h, expected no byte (cycle %0d)", bus.out_data, cyc);
      end else begin
        chk("out_data", 32'(bus.out_data), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic b);
    serial_in = b;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send_bit_rdy(input logic b, input int k, input logic r);
    serial_in = b;
    repeat (k) @(negedge clk);
    bus.out_ready = r;
    repeat (DIV - k) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) send_bit(b[i]);
  endtask

  initial begin
    bus.out_ready = 1'b0;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_valid",   32'(bus.out_valid), 32'd0);
      chk("rst_data",    32'(bus.out_data),  32'd0);
      chk("rst_locked",  32'(locked),        32'd0);
      chk("rst_overrun", 32'(overrun),       32'd0);
      chk("rst_lostlk",  32'(lock_lost),     32'd0);
      serial_in = ~serial_in;
    end
    reset_n       = 1'b1;
    bus.out_ready = 1'b1;

    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    send_bits(SYNC, 7, 1);
    chk("locked_early", 32'(locked), 32'd0);
    send_bit(SYNC[0]);
    chk("locked_rise", 32'(locked), 32'd1);

`ifdef SERIAL_RX_RELOCK_EN
    sb.push_back(8'h01); send_bits(8'h01, 7, 0);
    send_bits(SYNC, 7, 0);
    chk("ka_locked", 32'(locked), 32'd1);
    sb.push_back(8'h02); send_bits(8'h02, 7, 0);
    chk("ka_no_loss", 32'(lock_lost), 32'd0);
    sb.push_back(8'h03); send_bits(8'h03, 7, 0);
    chk("lost_pulse",  32'(lock_lost),     32'd1);
    chk("lost_locked", 32'(locked),        32'd0);
    chk("lost_valid",  32'(bus.out_valid), 32'd1);
    chk("lost_data",   32'(bus.out_data),  32'h03);
    @(negedge clk);
    chk("lost_end",    32'(lock_lost),     32'd0);
    chk("hunt_locked", 32'(locked),        32'd0);
`else
    // Lock and deliver.
    sb.push_back(8'h3C); send_bits(8'h3C, 7, 0);
    chk("3c_valid", 32'(bus.out_valid), 32'd1);
    sb.push_back(8'hC3); send_bit(1'b1);
    chk("3c_one_clk", 32'(bus.out_valid), 32'd0);
    send_bits(8'hC3, 6, 0);

    // Backpressure: 11 held, 22 dropped.
    sb.push_back(8'h11); send_bit(1'b0);
    chk("gap_24", 32'(xfer_cyc[1] - xfer_cyc[0]), 32'd24);
    chk("c3_one_clk", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;
    send_bits(8'h11, 6, 0);
    chk("bp_valid",    32'(bus.out_valid), 32'd1);
    chk("bp_data",     32'(bus.out_data),  32'h11);
    chk("bp_no_ovr",   32'(overrun),       32'd0);
    send_bits(8'h22, 7, 0);
    chk("ovr_data",    32'(bus.out_data),  32'h11);
    chk("ovr_valid",   32'(bus.out_valid), 32'd1);
    chk("ovr_set",     32'(overrun),       32'd1);
    sb.push_back(8'h44); send_bit(1'b0);
    chk("bp_hold",     32'(bus.out_data),  32'h11);
    bus.out_ready = 1'b1;
    send_bit(1'b1);
    chk("bp_drained",  32'(bus.out_valid), 32'd0);
    send_bits(8'h44, 5, 0);

    // Simultaneous accept and load.
    sb.push_back(8'h55); send_bit(1'b0);
    bus.out_ready = 1'b0;
    send_bits(8'h55, 6, 0);
    chk("sim_held", 32'(bus.out_data), 32'h55);
    sb.push_back(8'h66); send_bits(8'h66, 7, 1);
    chk("sim_still", 32'(bus.out_data), 32'h55);
    send_bit_rdy(1'b0, 2, 1'b1);
    chk("sim_valid", 32'(bus.out_valid), 32'd1);
    chk("sim_data",  32'(bus.out_data),  32'h66);
    chk("sim_ovr",   32'(overrun),       32'd1);

    // Mid-byte reset.
    send_bits(8'hF0, 7, 4);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_locked",  32'(locked),        32'd0);
    chk("mid_valid",   32'(bus.out_valid), 32'd0);
    chk("mid_overrun", 32'(overrun),       32'd0);
    reset_n = 1'b1;
    send_bits(SYNC, 7, 0);
    chk("relock", 32'(locked), 32'd1);
    sb.push_back(8'h5A); send_bits(8'h5A, 7, 0);
    sb.push_back(SYNC);  send_bits(SYNC, 7, 0);
    chk("sync_delivered", 32'(bus.out_data), 32'(SYNC));
`endif

    repeat (4) @(negedge clk);
    chk("sb_empty",   32'(sb.size()), 32'd0);
    chk("xfer_count", 32'(n_xfer),    32'(EXP_XFERS));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
